seq_player: RTL and testbench

- Reads the stored FPGA colour sequence (64-bit register, 16 four-bit one-hot LED codes) and plays it back on the four game LEDs.
- Timing per step depends on the selected difficulty level.
- Raises a one-cycle completion pulse that feeds the control FSM as end_FPGA.
- Sits between the FPGA sequence register and the LED outputs. It is the reader/display end of the sequence-writer path.

---
 rtl/seq_player.sv | 194 +++++++++++++++++++
 tb/tb_seq_player.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_player.sv
// seq_player: plays back the stored FPGA colour sequence on the four game LEDs.
// Each step shows one nibble of the latched sequence for a level-dependent
// on-time, then a dark gap. A one-cycle done pulse follows the last gap.
//
// Ports:
//   CLOCK_50  in   system clock (rising edge)
//   reset_n   in   asynchronous active-low reset
//   start     in   playback request, sampled only in IDLE
//   abort     in   synchronous cancel, returns to IDLE without done
//   seq[63:0] in   sequence, newest code in bits 63:60
//   round[3:0] in  current round, steps played = round+1
//   level[1:0] in  difficulty, selects on-time
//   leds[3:0] out  LED drive for the current step
//   busy      out  high while showing or in a gap
//   done      out  one-cycle pulse after the last gap
//   step_idx[3:0] out  0-based index of the step being shown
module seq_player #(
  parameter int unsigned TICK_DIV  = 12500000,
  parameter int unsigned GAP_TICKS = 1
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [63:0] seq,
  input  logic [3:0]  round,
  input  logic [1:0]  level,
  output logic [3:0]  leds,
  output logic        busy,
  output logic        done,
  output logic [3:0]  step_idx
);

  localparam int unsigned CYC_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned MAX_TICKS = (GAP_TICKS > 4) ? GAP_TICKS : 4;
  localparam int unsigned TICK_W    = $clog2(MAX_TICKS + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SHOW = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CYC_W-1:0]    cyc_q, cyc_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [63:0]         seq_q, seq_d;
  logic [3:0]          round_q, round_d;
  logic [1:0]          level_q, level_d;
  logic [3:0]          leds_q, leds_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [3:0]          step_q, step_d;

  logic                tick_end;
  logic [TICK_W-1:0]   on_last;

  // Selects nibble i of a 64-bit sequence.
  function automatic logic [3:0] nib(input logic [63:0] s, input logic [3:0] i);
    return s[{i, 2'b00} +: 4];
  endfunction

  // Last tick index of the on-time for the latched level.
  always_comb begin
    on_last = '0;
    case (level_q)
      2'b00:   on_last = TICK_W'(3);
      2'b01:   on_last = TICK_W'(1);
      default: on_last = TICK_W'(0);
    endcase
  end

  assign tick_end = (cyc_q == CYC_W'(TICK_DIV - 1));

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    tick_d  = tick_q;
    seq_d   = seq_q;
    round_d = round_q;
    level_d = level_q;
    leds_d  = leds_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    step_d  = step_q;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          seq_d   = seq;
          round_d = round;
          level_d = level;
          step_d  = 4'd0;
          cyc_d   = '0;
          tick_d  = '0;
          leds_d  = nib(seq, 4'(4'd15 - round));
          busy_d  = 1'b1;
          state_d = S_SHOW;
        end
      end

      S_SHOW: begin
        if (tick_end) begin
          cyc_d  = '0;
          tick_d = tick_q + TICK_W'(1);
        end else begin
          cyc_d  = cyc_q + CYC_W'(1);
        end
        if (tick_end && (tick_q == on_last)) begin
          cyc_d   = '0;
          tick_d  = '0;
          leds_d  = 4'd0;
          state_d = S_GAP;
        end
      end

      S_GAP: begin
        if (tick_end) begin
          cyc_d  = '0;
          tick_d = tick_q + TICK_W'(1);
        end else begin
          cyc_d  = cyc_q + CYC_W'(1);
        end
        if (tick_end && (tick_q == TICK_W'(GAP_TICKS - 1))) begin
          cyc_d  = '0;
          tick_d = '0;
          if (step_q == round_q) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            step_d  = step_q + 4'd1;
            leds_d  = nib(seq_q, 4'(4'd15 - round_q + step_q + 4'd1));
            state_d = S_SHOW;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides every other transition outside IDLE.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cyc_d   = '0;
      tick_d  = '0;
      leds_d  = 4'd0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      step_d  = 4'd0;
    end
  end

  // State and output registers.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      tick_q  <= '0;
      seq_q   <= '0;
      round_q <= '0;
      level_q <= '0;
      leds_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      tick_q  <= tick_d;
      seq_q   <= seq_d;
      round_q <= round_d;
      level_q <= level_d;
      leds_q  <= leds_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      step_q  <= step_d;
    end
  end

  assign leds     = leds_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign step_idx = step_q;

endmodule

// File: tb/tb_seq_player.sv
// Testbench for seq_player with TICK_DIV=4, GAP_TICKS=1. Expected per-cycle
// outputs are queued when playback starts; a monitor pops and compares on
// every cycle the DUT is busy or pulsing done.
module tb_seq_player;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [63:0] seq;
  logic [3:0]  round;
  logic [1:0]  level;
  logic [3:0]  leds;
  logic        busy;
  logic        done;
  logic [3:0]  step_idx;

  typedef struct packed {
    logic [3:0] leds;
    logic       busy;
    logic       done;
    logic [3:0] step;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   cyc_cnt = 0;
  int   t_start = 0;
  int   done_at = 0;

  seq_player #(.TICK_DIV(4), .GAP_TICKS(1)) dut (
    .CLOCK_50 (clk),
    .reset_n  (reset_n),
    .start    (start),
    .abort    (abort),
    .seq      (seq),
    .round    (round),
    .level    (level),
    .leds     (leds),
    .busy     (busy),
    .done     (done),
    .step_idx (step_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", nm, $time, act, want);
    end
  endtask

  // Queue the expected per-cycle outputs of one playback (first `keep` cycles).
  task automatic push_play(input logic [63:0] s, input int r, input int lv,
                           input int keep, input int done_rel);
    int   on_cyc;
    int   cnt;
    int   idx;
    exp_t e;
    on_cyc = (lv == 0) ? 16 : (lv == 1) ? 8 : 4;
    cnt = 0;
    for (int st = 0; st <= r; st++) begin
      idx = 15 - r + st;
      for (int c = 0; c < on_cyc + 4; c++) begin
        e.leds = (c < on_cyc) ? s[idx*4 +: 4] : 4'd0;
        e.busy = 1'b1;
        e.done = 1'b0;
        e.step = 4'(st);
        if (cnt < keep) exp_q.push_back(e);
        cnt++;
      end
    end
    e.leds = 4'd0;
    e.busy = 1'b0;
    e.done = 1'b1;
    e.step = 4'(r);
    if (cnt < keep) exp_q.push_back(e);
    t_start = cyc_cnt;
    done_at = done_rel;
  endtask

  // Issue a one-cycle start; returns at the negedge of cycle 1.
  task automatic do_start(input logic [63:0] s, input int r, input int lv,
                          input int keep, input int done_rel);
    @(negedge clk);
    seq   = s;
    round = 4'(r);
    level = 2'(lv);
    start = 1'b1;
    @(posedge clk);
    #1;
    push_play(s, r, lv, keep, done_rel);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Monitor: compares outputs against the scoreboard every cycle.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      cyc_cnt++;
      if (busy || done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", {30'd0, busy, done}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("play_out", {22'd0, leds, busy, done, step_idx}, {22'd0, e});
          if (done && done_at != 0)
            check("done_cycle", 32'(cyc_cnt - t_start), 32'(done_at));
        end
      end else begin
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("missing_out", {30'd0, busy, done}, {30'd0, e.busy, e.done});
        end
        check("idle_leds", {28'd0, leds}, 32'd0);
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    seq     = '0;
    round   = '0;
    level   = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_leds", {28'd0, leds}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_step", {28'd0, step_idx}, 32'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single step
    do_start(64'h1000_0000_0000_0000, 0, 0, 1000, 21);
    repeat (25) @(negedge clk);

    // Three steps, fast level
    do_start(64'h8420_0000_0000_0000, 2, 2, 1000, 25);
    repeat (30) @(negedge clk);

    // Input stability: changes and a second start during playback
    do_start(64'h2100_0000_0000_0000, 1, 1, 1000, 25);
    repeat (2) @(negedge clk);
    seq   = 64'hFFFF_FFFF_FFFF_FFFF;
    round = 4'd15;
    level = 2'd0;
    repeat (7) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (25) @(negedge clk);
    seq   = '0;
    round = '0;
    level = '0;

    // Abort at cycle 6 of a round=3 playback
    do_start(64'h1248_0000_0000_0000, 3, 0, 6, 0);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_leds", {28'd0, leds}, 32'd0);
    check("abort_step", {28'd0, step_idx}, 32'd0);
    repeat (100) @(negedge clk);
    do_start(64'h1248_0000_0000_0000, 3, 0, 1000, 81);
    repeat (85) @(negedge clk);

    // Async reset mid-SHOW
    do_start(64'h4000_0000_0000_0000, 0, 0, 4, 0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_leds", {28'd0, leds}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_step", {28'd0, step_idx}, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("arst_idle_busy", {31'd0, busy}, 32'd0);

    // Full sequence, nibble i holds code i (nibble 0 is dark)
    do_start(64'hFEDC_BA98_7654_3210, 15, 3, 1000, 129);
    repeat (135) @(negedge clk);

    check("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
